// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Upstream control stage for an 8-bit ALU. Accepts one 16-bit instruction at a
// time, holds a 4 x 8-bit register file and walks the ALU through a fixed
// operand-load / execute / writeback sequence. Load-immediate is executed
// internally and never touches the ALU.
//
// Instruction formats:
//   ALU op : [15:12] func, [11:10] rd, [9:8] ra, [7:6] rb, [5:0] ignored
//   LDI    : [15:12] LDI_OP, [11:10] rd, [7:0] imm, [9:8] ignored
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE and never while
// sync_reset is asserted; instr is ignored on every other edge, so holding
// instr_valid high while busy has no effect.
//
// Ports:
//   clk          in   system clock, rising-edge
//   sync_reset   in   synchronous active-high reset
//   instr        in   16-bit instruction word
//   instr_valid  in   instr is valid this cycle
//   instr_ready  out  sequencer can accept an instruction
//   alu_result   in   registered ALU result
//   bus          out  operand bus into the ALU
//   a_in         out  ALU A-operand load strobe
//   b_in         out  ALU B-operand load strobe
//   save_result  out  ALU result-register load strobe
//   func_sel     out  ALU function select
//   done         out  one-cycle pulse in the writeback cycle
//   dbg_sel      in   register-file observation address
//   dbg_data     out  combinational read of R[dbg_sel]
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int         DATA_W = 8,
    parameter logic [3:0] LDI_OP = 4'b0100
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] bus,
    output logic              a_in,
    output logic              b_in,
    output logic              save_result,
    output logic [3:0]        func_sel,
    output logic              done,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t state;

    // Register file
    logic [DATA_W-1:0] regs [4];

    // Fields of the instruction being executed. ra is consumed on the
    // acceptance edge straight from instr, so it is not kept.
    logic [3:0]        func_q;
    logic [1:0]        rd_q;
    logic [1:0]        rb_q;
    logic [DATA_W-1:0] imm_q;

    // Fields of the instruction being offered
    logic [3:0] in_func;
    logic [1:0] in_rd;
    logic [1:0] in_ra;
    logic [1:0] in_rb;

    assign in_func = instr[15:12];
    assign in_rd   = instr[11:10];
    assign in_ra   = instr[9:8];
    assign in_rb   = instr[7:6];

    logic accept;
    assign accept = instr_ready && instr_valid;

    assign instr_ready = (state == IDLE) && !sync_reset;
    assign dbg_data    = regs[dbg_sel];

    // Single state machine. Every output is registered and set on the edge
    // that enters the state it belongs to, so each strobe lines up exactly
    // with the cycle the state is occupied.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state       <= IDLE;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            func_q      <= '0;
            rd_q        <= '0;
            rb_q        <= '0;
            imm_q       <= '0;
            bus         <= '0;
            a_in        <= 1'b0;
            b_in        <= 1'b0;
            save_result <= 1'b0;
            func_sel    <= 4'b0000;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        func_q <= in_func;
                        rd_q   <= in_rd;
                        rb_q   <= in_rb;
                        imm_q  <= DATA_W'(instr[7:0]);
                        if (in_func == LDI_OP) begin
                            // Load-immediate skips the ALU entirely.
                            state <= WB;
                            done  <= 1'b1;
                        end else begin
                            // Operand A is read here; no write can land
                            // before LOAD_A, so this value is current.
                            state    <= LOAD_A;
                            bus      <= regs[in_ra];
                            a_in     <= 1'b1;
                            func_sel <= in_func;
                        end
                    end
                end

                LOAD_A: begin
                    state <= LOAD_B;
                    bus   <= regs[rb_q];
                    a_in  <= 1'b0;
                    b_in  <= 1'b1;
                end

                LOAD_B: begin
                    state       <= EXEC;
                    bus         <= '0;
                    b_in        <= 1'b0;
                    save_result <= 1'b1;
                end

                EXEC: begin
                    // The ALU captures its result on this edge, so
                    // alu_result is valid throughout WB.
                    state       <= WB;
                    save_result <= 1'b0;
                    done        <= 1'b1;
                end

                WB: begin
                    // Operands were captured by the ALU earlier, so an
                    // in-place write (rd == ra or rd == rb) is safe.
                    if (func_q == LDI_OP) regs[rd_q] <= imm_q;
                    else                  regs[rd_q] <= alu_result;
                    state    <= IDLE;
                    done     <= 1'b0;
                    func_sel <= 4'b0000;
                end

                default: begin
                    state       <= IDLE;
                    bus         <= '0;
                    a_in        <= 1'b0;
                    b_in        <= 1'b0;
                    save_result <= 1'b0;
                    func_sel    <= 4'b0000;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Pairs alu_sequencer with a small behavioural ALU (operand registers A/B and a
// registered result; async reset tied to sync_reset) and checks the sequencer
// against a register-file model kept as a plain array.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam logic [3:0] LDI = 4'b0100;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  alu_result;
    logic [7:0]  bus;
    logic        a_in, b_in, save_result, done;
    logic [3:0]  func_sel;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;

    alu_sequencer dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_result  (alu_result),
        .bus         (bus),
        .a_in        (a_in),
        .b_in        (b_in),
        .save_result (save_result),
        .func_sel    (func_sel),
        .done        (done),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // ALU function table: 0001 add, 0010 sub, 0011 and, 0101 or, 0110 xor,
    // anything else yields 0x00.
    function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'b0001: return 8'(a + b);
            4'b0010: return 8'(a - b);
            4'b0011: return a & b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- behavioural ALU ----------------
    logic [7:0] alu_a, alu_b, alu_res;
    assign alu_result = alu_res;
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_res <= '0;
        end else begin
            if (a_in)        alu_a   <= bus;
            if (b_in)        alu_b   <= bus;
            if (save_result) alu_res <= alu_fn(func_sel, alu_a, alu_b);
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] model_r [4];
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_alu(input logic [3:0] f, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
        return {f, rd, ra, rb, 6'b0};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {LDI, rd, 2'b00, imm};
    endfunction

    // ---------------- driver ----------------
    // pre=1: caller has already presented ins with instr_valid high in the
    // current cycle (ready is high). hold=1: keep instr_valid high after
    // acceptance and swap instr to nxt.
    task automatic exec(input logic [15:0] ins, input bit pre, input bit hold, input logic [15:0] nxt);
        logic [3:0] f;
        logic [1:0] rd, ra, rb;
        logic [7:0] va, vb;
        int cnt;
        f  = ins[15:12];
        rd = ins[11:10];
        ra = ins[9:8];
        rb = ins[7:6];
        if (!pre) begin
            @(negedge clk);
            cnt = 0;
            while (!instr_ready && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            instr       = ins;
            instr_valid = 1'b1;
        end
        check("accept_ready", {15'b0, instr_ready}, 16'd1);
        va = model_r[ra];
        vb = model_r[rb];
        exp_q.push_back((f == LDI) ? ins[7:0] : alu_fn(f, va, vb));

        @(negedge clk);  // T+1
        if (hold) instr = nxt;
        else      instr_valid = 1'b0;

        if (f == LDI) begin
            check("ldi_done",    {15'b0, done}, 16'd1);
            check("ldi_strobes", {13'b0, a_in, b_in, save_result}, 16'd0);
            check("ldi_ready",   {15'b0, instr_ready}, 16'd0);
            check("ldi_bus",     {8'b0, bus}, 16'd0);
        end else begin
            check("la_strobes", {13'b0, a_in, b_in, save_result}, 16'b100);
            check("la_bus",     {8'b0, bus}, {8'b0, va});
            check("la_func",    {12'b0, func_sel}, {12'b0, f});
            check("la_ready",   {15'b0, instr_ready}, 16'd0);
            check("la_done",    {15'b0, done}, 16'd0);
            @(negedge clk);  // T+2
            check("lb_strobes", {13'b0, a_in, b_in, save_result}, 16'b010);
            check("lb_bus",     {8'b0, bus}, {8'b0, vb});
            check("lb_ready",   {15'b0, instr_ready}, 16'd0);
            @(negedge clk);  // T+3
            check("ex_strobes", {13'b0, a_in, b_in, save_result}, 16'b001);
            check("ex_bus",     {8'b0, bus}, 16'd0);
            check("ex_func",    {12'b0, func_sel}, {12'b0, f});
            check("ex_ready",   {15'b0, instr_ready}, 16'd0);
            @(negedge clk);  // T+4
            check("wb_done",    {15'b0, done}, 16'd1);
            check("wb_strobes", {13'b0, a_in, b_in, save_result}, 16'd0);
            check("wb_func",    {12'b0, func_sel}, {12'b0, f});
            check("wb_ready",   {15'b0, instr_ready}, 16'd0);
        end
        model_r[rd] = exp_q[0];

        @(negedge clk);  // write now visible, back in IDLE
        dbg_sel = rd;
        #1;
        check("wb_data",    {8'b0, dbg_data}, {8'b0, exp_q.pop_front()});
        check("idle_ready", {15'b0, instr_ready}, 16'd1);
        check("idle_done",  {15'b0, done}, 16'd0);
        check("idle_func",  {12'b0, func_sel}, 16'd0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check(tag, {8'b0, dbg_data}, {8'b0, model_r[i]});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 4; i++) model_r[i] = 8'h00;

        // Reset for two cycles
        sync_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready_low", {15'b0, instr_ready}, 16'd0);
        sync_reset = 1'b0;
        @(negedge clk);
        check("rst_ready",   {15'b0, instr_ready}, 16'd1);
        check("rst_bus",     {8'b0, bus}, 16'd0);
        check("rst_strobes", {12'b0, a_in, b_in, save_result, done}, 16'd0);
        check("rst_func",    {12'b0, func_sel}, 16'd0);
        check_regs("rst_regs");

        // LDI then ADD
        exec(mk_ldi(2'd1, 8'h05), 1'b0, 1'b0, 16'h0);
        exec(mk_ldi(2'd2, 8'h03), 1'b0, 1'b0, 16'h0);
        exec(mk_alu(4'b0001, 2'd0, 2'd1, 2'd2), 1'b0, 1'b0, 16'h0);
        check("add_r0", {8'b0, model_r[0]}, 16'h0008);

        // SUB wraparound, in place
        exec(mk_ldi(2'd1, 8'h03), 1'b0, 1'b0, 16'h0);
        exec(mk_ldi(2'd2, 8'h05), 1'b0, 1'b0, 16'h0);
        exec(mk_alu(4'b0010, 2'd1, 2'd1, 2'd2), 1'b0, 1'b0, 16'h0);
        check_regs("sub_regs");
        dbg_sel = 2'd1; #1;
        check("sub_r1", {8'b0, dbg_data}, 16'h00FE);

        // Backpressure: XOR held valid during an ADD
        exec(mk_alu(4'b0001, 2'd3, 2'd0, 2'd1), 1'b0, 1'b1, mk_alu(4'b0110, 2'd2, 2'd3, 2'd0));
        exec(mk_alu(4'b0110, 2'd2, 2'd3, 2'd0), 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        check("no_reaccept_a", {15'b0, a_in}, 16'd0);
        check("no_reaccept_d", {15'b0, done}, 16'd0);
        check_regs("bp_regs");

        // Reset mid-operation, during LOAD_B of ADD rd=3
        @(negedge clk);
        instr       = mk_alu(4'b0001, 2'd3, 2'd0, 2'd1);
        instr_valid = 1'b1;
        @(negedge clk);  // LOAD_A
        instr_valid = 1'b0;
        @(negedge clk);  // LOAD_B
        check("mid_lb", {15'b0, b_in}, 16'd1);
        sync_reset = 1'b1;
        @(negedge clk);
        check("mid_done0",  {15'b0, done}, 16'd0);
        check("mid_ready0", {15'b0, instr_ready}, 16'd0);
        sync_reset = 1'b0;
        for (int i = 0; i < 4; i++) model_r[i] = 8'h00;
        @(negedge clk);
        check("mid_done1",  {15'b0, done}, 16'd0);
        check("mid_ready1", {15'b0, instr_ready}, 16'd1);
        check("mid_strobe", {13'b0, a_in, b_in, save_result}, 16'd0);
        check_regs("mid_regs");

        // Unimplemented opcode
        exec(mk_ldi(2'd0, 8'hAA), 1'b0, 1'b0, 16'h0);
        exec(mk_alu(4'b0111, 2'd0, 2'd1, 2'd2), 1'b0, 1'b0, 16'h0);
        check("unimp_r0", {8'b0, model_r[0]}, 16'h0000);

        // Randomized instruction mix
        for (int n = 0; n < 40; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom());
            if ($urandom_range(0, 2) == 0) ins[15:12] = LDI;
            exec(ins, 1'b0, 1'b0, 16'h0);
        end
        check_regs("rand_regs");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
